// File: rtl/wb_sevenseg_scan.sv
// Wishbone slave for a multiplexed common-anode 7-segment display: registered bus
// with one wait state, a frame latch taken at each scan wrap, and a registered pin stage.
module wb_sevenseg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] an_out
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [DW-1:0]         data_q, data_d, fdata_q;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, blank_q, blank_d, fdp_q, fblank_q;
  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  ack_q, ack_d, wr_en;
  logic [31:0]           dat_o_q, rd_data, wmask, data32_old, data32_new;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic                  pre_wrap, idx_wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank, cur_uz, uz, lz, bcd_hide;
  logic                  unused_bits;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Bus: ack_d marks the cycle a request is accepted; writes and read data commit then.
  always_comb begin
    ack_d = wb_stb_i & wb_cyc_i & ~ack_q;
    wr_en = ack_d & wb_we_i;
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{wb_sel_i[b]}};
    data32_old = '0;
    data32_old[DW-1:0] = data_q;
    data32_new = (data32_old & ~wmask) | (wb_dat_i & wmask);
    rd_data = '0;
    case (wb_adr_i[3:2])
      2'd0:    rd_data = data32_old;
      2'd1:    rd_data[2:0] = ctrl_q;
      2'd2:    rd_data[NUM_DIGITS-1:0] = dp_q;
      default: rd_data[NUM_DIGITS-1:0] = blank_q;
    endcase
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (wr_en) begin
      case (wb_adr_i[3:2])
        2'd0:    data_d = data32_new[DW-1:0];
        2'd1:    if (wb_sel_i[0]) ctrl_d = wb_dat_i[2:0];
        2'd2:    if (wb_sel_i[0]) dp_d = wb_dat_i[NUM_DIGITS-1:0];
        default: if (wb_sel_i[0]) blank_d = wb_dat_i[NUM_DIGITS-1:0];
      endcase
    end
  end

  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    idx_wrap = pre_wrap & (idx_q == IDX_LAST);
    pre_d    = pre_wrap ? '0 : pre_q + PW'(1);
    idx_d    = idx_q;
    if (pre_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // uz walks from the top digit down: set while every digit at or above i is zero.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_uz    = 1'b0;
    uz        = 1'b1;
    an_d      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      uz = uz & (fdata_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        cur_nib   = fdata_q[4*i +: 4];
        cur_dp    = fdp_q[i];
        cur_blank = fblank_q[i];
        cur_uz    = uz;
        an_d[i]   = ctrl_q[0];
      end
    end
    lz       = ctrl_q[2] & cur_uz & (idx_q != '0);
    bcd_hide = ctrl_q[1] & (cur_nib > 4'd9);
    seg_d    = (cur_blank | lz | bcd_hide) ? 7'h00 : glyph(cur_nib);
    dpo_d    = cur_dp;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q   <= '0;
      ctrl_q   <= 3'b001;
      dp_q     <= '0;
      blank_q  <= '0;
      fdata_q  <= '0;
      fdp_q    <= '0;
      fblank_q <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      ack_q    <= 1'b0;
      dat_o_q  <= '0;
      an_q     <= '0;
      seg_q    <= '0;
      dpo_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      // Latch the pre-write registers so a write on the wrap cycle lands in the next frame.
      if (idx_wrap) begin
        fdata_q  <= data_q;
        fdp_q    <= dp_q;
        fblank_q <= blank_q;
      end
      pre_q <= pre_d;
      idx_q <= idx_d;
      ack_q <= ack_d;
      if (ack_d) dat_o_q <= rd_data;
      an_q  <= an_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
    end
  end

  assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o    = dat_o_q;
  assign seg_out     = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp_out      = (SEG_ACTIVE_LOW != 0) ? ~dpo_q : dpo_q;
  assign an_out      = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], data32_new};

endmodule
